// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync + glitch filter, 11-bit deframer, FWFT FIFO of {err, byte}.
// Define PS2_RX_STATS_EN to build the FRAMES_OK / FRAMES_ERR saturating counters.
module ps2_rx_fifo #(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned TIMEOUT_US  = 1000,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned PARITY_ODD  = 1
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            PS2_CLK_IN,
    input  logic                            PS2_DATA_IN,
    input  logic                            RX_ENABLE,
    input  logic                            RD_EN,
    output logic                            RD_VALID,
    output logic [7:0]                      RD_DATA,
    output logic [1:0]                      RD_ERR,
    output logic [$clog2(FIFO_DEPTH):0]     FIFO_COUNT,
    output logic                            OVERFLOW,
    input  logic                            OVERFLOW_CLR,
    output logic                            TIMEOUT,
    output logic [15:0]                     FRAMES_OK,
    output logic [15:0]                     FRAMES_ERR
);

    localparam int unsigned TMO = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam int unsigned TW  = $clog2(TMO + 1);
    localparam int unsigned FW  = $clog2(FILTER_LEN + 1);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StData, StParity, StStop, StPush} state_t;

    logic          r_clk_meta, r_clk_sync, r_clk_filt, r_clk_prev;
    logic          r_dat_meta, r_dat_sync, r_dat_filt;
    logic [FW-1:0] r_clk_fcnt, r_dat_fcnt;
    logic          w_fe;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_filt <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
            r_dat_filt <= 1'b1;
            r_clk_fcnt <= '0;
            r_dat_fcnt <= '0;
        end else begin
            r_clk_meta <= PS2_CLK_IN;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= PS2_DATA_IN;
            r_dat_sync <= r_dat_meta;
            r_clk_prev <= r_clk_filt;
            // Filtered line follows only after FILTER_LEN consecutive differing cycles
            if (r_clk_sync == r_clk_filt) begin
                r_clk_fcnt <= '0;
            end else if (r_clk_fcnt == FW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_sync;
                r_clk_fcnt <= '0;
            end else begin
                r_clk_fcnt <= r_clk_fcnt + 1'b1;
            end
            if (r_dat_sync == r_dat_filt) begin
                r_dat_fcnt <= '0;
            end else if (r_dat_fcnt == FW'(FILTER_LEN - 1)) begin
                r_dat_filt <= r_dat_sync;
                r_dat_fcnt <= '0;
            end else begin
                r_dat_fcnt <= r_dat_fcnt + 1'b1;
            end
        end
    end

    assign w_fe = r_clk_prev & ~r_clk_filt;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [2:0]    r_bitcnt, w_bitcnt_nxt;
    logic [1:0]    r_err, w_err_nxt;
    logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic          w_tmo_hit;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_err     <= '0;
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_err     <= w_err_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bitcnt_nxt  = r_bitcnt;
        w_err_nxt     = r_err;
        w_timeout_nxt = 1'b0;
        w_tmo_hit     = (r_state != StIdle) && !w_fe && (r_tmo_cnt == TW'(TMO - 1));
        w_tmo_cnt_nxt = (r_state == StIdle || w_fe) ? '0 : r_tmo_cnt + 1'b1;
        unique case (r_state)
            StIdle: begin
                if (w_fe && RX_ENABLE && !r_dat_filt) begin
                    w_state_nxt  = StData;
                    w_bitcnt_nxt = '0;
                    w_err_nxt    = '0;
                end
            end
            StData: begin
                if (w_fe) begin
                    w_shift_nxt  = {r_dat_filt, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 1'b1;
                    if (r_bitcnt == 3'd7) w_state_nxt = StParity;
                end
            end
            StParity: begin
                if (w_fe) begin
                    w_err_nxt[0] = (PARITY_ODD != 0) ? ~(^{r_shift, r_dat_filt})
                                                     : (^{r_shift, r_dat_filt});
                    w_state_nxt  = StStop;
                end
            end
            StStop: begin
                if (w_fe) begin
                    w_err_nxt[1] = ~r_dat_filt;
                    w_state_nxt  = StPush;
                end
            end
            StPush: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        if (w_tmo_hit) begin
            w_state_nxt   = StIdle;
            w_timeout_nxt = 1'b1;
            w_tmo_cnt_nxt = '0;
        end
    end

    assign TIMEOUT = r_timeout;

    logic [9:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0] r_count;
    logic        r_overflow;
    logic        w_push, w_pop, w_wr, w_full;
    logic [9:0]  w_head;

    assign w_push = (r_state == StPush);
    assign w_full = (r_count == (AW + 1)'(FIFO_DEPTH));
    assign w_pop  = RD_EN && (r_count != '0);
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge CLK) begin
        if (w_wr) r_mem[r_wr_ptr] <= {r_err, r_shift};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop) r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
            // New overflow wins over a same-cycle clear
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            else if (OVERFLOW_CLR) r_overflow <= 1'b0;
        end
    end

    assign RD_VALID   = (r_count != '0);
    assign w_head     = RD_VALID ? r_mem[r_rd_ptr] : 10'd0;
    assign RD_DATA    = w_head[7:0];
    assign RD_ERR     = w_head[9:8];
    assign FIFO_COUNT = r_count;
    assign OVERFLOW   = r_overflow;

`ifdef PS2_RX_STATS_EN
    logic [15:0] r_frames_ok, r_frames_err;
    logic        w_ok_evt, w_err_evt;

    assign w_ok_evt  = w_push && (r_err == 2'b00);
    assign w_err_evt = (w_push && (r_err != 2'b00)) || w_tmo_hit;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_frames_ok  <= '0;
            r_frames_err <= '0;
        end else begin
            if (w_ok_evt && r_frames_ok != 16'hFFFF) r_frames_ok <= r_frames_ok + 1'b1;
            if (w_err_evt && r_frames_err != 16'hFFFF) r_frames_err <= r_frames_err + 1'b1;
        end
    end

    assign FRAMES_OK  = r_frames_ok;
    assign FRAMES_ERR = r_frames_err;
`else
    assign FRAMES_OK  = 16'd0;
    assign FRAMES_ERR = 16'd0;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: random PS/2 frames vs a byte/parity/stop model and FIFO queue.
module tb_ps2_rx_fifo;

    localparam int unsigned CLK_FREQ_HZ = 1000000;
    localparam int unsigned TIMEOUT_US  = 200;
    localparam int unsigned FILTER_LEN  = 4;
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned TMO         = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam int unsigned HALF        = 20;
    // Raw edge -> 2 sync flops -> FILTER_LEN filter -> FE cycle -> PUSH cycle starts
    localparam int unsigned PUSH_LAT    = 2 + FILTER_LEN + 1;

    logic        CLK = 1'b0;
    logic        RESET, ps2_clk, ps2_dat, rx_en, ovf_clr;
    logic        rd_en_auto, rd_en_dir, auto_rd;
    logic        RD_VALID, OVERFLOW, TIMEOUT;
    logic [7:0]  RD_DATA;
    logic [1:0]  RD_ERR;
    logic [3:0]  FIFO_COUNT;
    logic [15:0] FRAMES_OK, FRAMES_ERR;

    int          n_checks = 0;
    int          n_err = 0;
    int          m_ok = 0;
    int          m_bad = 0;
    logic [9:0]  exp_q[$];

    always #5 CLK = ~CLK;

    ps2_rx_fifo #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .TIMEOUT_US (TIMEOUT_US),
        .FILTER_LEN (FILTER_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PS2_CLK_IN  (ps2_clk),
        .PS2_DATA_IN (ps2_dat),
        .RX_ENABLE   (rx_en),
        .RD_EN       (rd_en_auto | rd_en_dir),
        .RD_VALID    (RD_VALID),
        .RD_DATA     (RD_DATA),
        .RD_ERR      (RD_ERR),
        .FIFO_COUNT  (FIFO_COUNT),
        .OVERFLOW    (OVERFLOW),
        .OVERFLOW_CLR(ovf_clr),
        .TIMEOUT     (TIMEOUT),
        .FRAMES_OK   (FRAMES_OK),
        .FRAMES_ERR  (FRAMES_ERR)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [9:0] model_entry(input logic [7:0] d, input logic p, input logic s);
        int   ones;
        logic perr;
        ones = $countones(d) + int'(p);
        perr = (PARITY_ODD != 0) ? (ones % 2 == 0) : (ones % 2 == 1);
        return {~s, perr, d};
    endfunction

    task automatic pulse_bit(input logic b);
        ps2_dat = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop_bit,
                              input bit do_pop, input bit chk_lat, input bit drop_en);
        logic       p;
        logic [9:0] e;
        p = (PARITY_ODD != 0) ? ($countones(d) % 2 == 0) : ($countones(d) % 2 == 1);
        if (bad_par) p = ~p;
        pulse_bit(1'b0);
        if (drop_en) rx_en = 1'b0;
        for (int i = 0; i < 8; i++) pulse_bit(d[i]);
        pulse_bit(p);
        ps2_dat = stop_bit;
        tick(HALF);
        ps2_clk = 1'b0;
        e = model_entry(d, p, stop_bit);
        if (e[9:8] == 2'b00) m_ok++;
        else m_bad++;
        if (exp_q.size() < FIFO_DEPTH || do_pop) exp_q.push_back(e);
        for (int k = 1; k <= int'(HALF); k++) begin
            tick(1);
            if (do_pop && k == int'(PUSH_LAT)) rd_en_dir = 1'b1;
            if (do_pop && k == int'(PUSH_LAT) + 1) rd_en_dir = 1'b0;
            if (chk_lat && k == int'(PUSH_LAT)) check("lat_before", RD_VALID, 0);
            if (chk_lat && k == int'(PUSH_LAT) + 1) check("lat_valid", RD_VALID, 1);
        end
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        tick(HALF);
        rx_en = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000 && (exp_q.size() != 0 || RD_VALID); i++) tick(1);
        check("drain_queue", exp_q.size(), 0);
        check("drain_count", FIFO_COUNT, 0);
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head
    always @(negedge CLK) begin
        logic [9:0] e;
        if (!RESET && (rd_en_auto | rd_en_dir) && RD_VALID) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {RD_ERR, RD_DATA}, 10'h3FF);
                n_err += (({RD_ERR, RD_DATA} === 10'h3FF) ? 1 : 0);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", RD_DATA, e[7:0]);
                check("rd_err", RD_ERR, e[9:8]);
            end
        end
    end

    always @(posedge CLK) begin
        #1;
        rd_en_auto = auto_rd && ($urandom_range(0, 2) == 0);
    end

    initial begin
        #(1000000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tmo_pulses;
        RESET = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rx_en = 1'b1; ovf_clr = 1'b0;
        rd_en_dir = 1'b0; auto_rd = 1'b0; rd_en_auto = 1'b0;
        tick(5);
        RESET = 1'b0;
        tick(1);
        check("rst_valid", RD_VALID, 0);
        check("rst_data", RD_DATA, 0);
        check("rst_err", RD_ERR, 0);
        check("rst_count", FIFO_COUNT, 0);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_tmo", TIMEOUT, 0);
        check("rst_ok", FRAMES_OK, 0);
        check("rst_bad", FRAMES_ERR, 0);
        tick(20);

        // 0xFA with latency check and a single directed pop
        send_frame(8'hFA, 0, 1'b1, 0, 1, 0);
        check("fa_count", FIFO_COUNT, 1);
        check("fa_valid", RD_VALID, 1);
        check("fa_data", RD_DATA, 8'hFA);
        rd_en_dir = 1'b1;
        tick(1);
        rd_en_dir = 1'b0;
        check("fa_count_after", FIFO_COUNT, 0);
        check("fa_valid_after", RD_VALID, 0);

        // Parity and stop errors
        auto_rd = 1'b1;
        send_frame(8'h08, 1, 1'b1, 0, 0, 0);
        send_frame(8'h08, 0, 1'b0, 0, 0, 0);
        wait_drain();

        // Aborted frame: start + 4 data bits, then line idles high
        pulse_bit(1'b0);
        for (int i = 0; i < 4; i++) pulse_bit(1'b1);
        ps2_dat = 1'b1;
        tmo_pulses = 0;
        for (int i = 0; i < 3 * int'(TMO); i++) begin
            tick(1);
            if (TIMEOUT) tmo_pulses++;
        end
        m_bad++;
        check("tmo_pulses", tmo_pulses, 1);
        check("tmo_count", FIFO_COUNT, 0);
        send_frame(8'hAA, 0, 1'b1, 0, 0, 0);
        wait_drain();

        // Short clock glitch while idle with data low
        ps2_dat = 1'b0;
        tick(10);
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(10);
        ps2_dat = 1'b1;
        tick(30);
        check("glitch_count", FIFO_COUNT, 0);
        send_frame(8'h55, 0, 1'b1, 0, 0, 0);
        wait_drain();

        // Overflow, clear, then push coinciding with pop while full
        auto_rd = 1'b0;
        tick(5);
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1'b1, 0, 0, 0);
        check("ovf_count", FIFO_COUNT, 8);
        check("ovf_set", OVERFLOW, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_clr", OVERFLOW, 0);
        send_frame(8'h0A, 0, 1'b1, 1, 0, 0);
        check("pushpop_count", FIFO_COUNT, 8);
        check("pushpop_ovf", OVERFLOW, 0);
        auto_rd = 1'b1;
        wait_drain();

        // Reset with a stored entry and a partial frame in flight
        auto_rd = 1'b0;
        tick(5);
        send_frame(8'h33, 0, 1'b1, 0, 0, 0);
        pulse_bit(1'b0);
        for (int i = 0; i < 3; i++) pulse_bit(1'b0);
        ps2_dat = 1'b1;
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        exp_q.delete();
        m_ok = 0;
        m_bad = 0;
        check("mrst_count", FIFO_COUNT, 0);
        check("mrst_valid", RD_VALID, 0);
        check("mrst_ok", FRAMES_OK, 0);
        tick(40);

        // Randomised traffic with random reader stalls
        auto_rd = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0),
                       logic'($urandom_range(0, 5) != 0), 0, 0, ($urandom_range(0, 3) == 0));
        end
        wait_drain();

`ifdef PS2_RX_STATS_EN
        check("frames_ok", FRAMES_OK, m_ok);
        check("frames_err", FRAMES_ERR, m_bad);
`else
        check("frames_ok_tied", FRAMES_OK, 0);
        check("frames_err_tied", FRAMES_ERR, 0);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver for mouse and keyboard links. It synchronises and glitch-filters the PS/2 clock and data lines, then deframes 11-bit codewords: start, 8 data bits LSB-first, parity, stop. Received bytes are tagged with error status and buffered in a first-word-fall-through FIFO. Downstream protocol logic (mouse transceiver/packet assembler) drains the FIFO at its own pace instead of catching single-cycle strobes.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency; used to derive the timeout.
TIMEOUT_US, 1000, maximum gap between PS/2 clock falling edges inside a frame, in microseconds.
FILTER_LEN, 4, consecutive stable CLK cycles required before a filtered line changes; minimum 1.
FIFO_DEPTH, 8, FIFO entries; power of 2, minimum 2.
PARITY_ODD, 1, 1 = odd parity check (PS/2 standard), 0 = even parity check.

Ports:
CLK  in  1  system clock.
RESET  in  1  synchronous, active-high reset.
PS2_CLK_IN  in  1  raw PS/2 clock line, asynchronous.
PS2_DATA_IN  in  1  raw PS/2 data line, asynchronous.
RX_ENABLE  in  1  1 = new frames may start; 0 = idle, used while the host transmits.
RD_EN  in  1  pop the FIFO head; ignored when RD_VALID=0.
RD_VALID  out  1  FIFO not empty.
RD_DATA  out  8  head byte; valid when RD_VALID=1.
RD_ERR  out  2  head error code: bit0 = parity error, bit1 = stop-bit error.
FIFO_COUNT  out  clog2(FIFO_DEPTH)+1  occupied entries.
OVERFLOW  out  1  sticky; set when a frame is dropped because the FIFO is full.
OVERFLOW_CLR  in  1  clears OVERFLOW.
TIMEOUT  out  1  one-cycle pulse when a frame is aborted on timeout.
FRAMES_OK  out  16  statistics counter; see Optional Feature.
FRAMES_ERR  out  16  statistics counter; see Optional Feature.

Behaviour:
- Reset values: RD_VALID=0, RD_DATA=0, RD_ERR=0, FIFO_COUNT=0, OVERFLOW=0, TIMEOUT=0, FRAMES_OK=0, FRAMES_ERR=0.
- After reset: FSM in IDLE; filtered lines = 1; FIFO pointers = 0.
- Input conditioning: 2-flop synchroniser per line, then filter. A filtered line takes a new value only after the synchronised value has differed from it for FILTER_LEN consecutive cycles.
- Edge detection: a falling edge (FE) is filtered clock 1 in the previous cycle and 0 in the current cycle. All sampling uses filtered data on FE.
- Timeout limit: TMO = CLK_FREQ_HZ/1000000*TIMEOUT_US cycles.
  - Counter clears on every FE and while in IDLE.
  - In any non-IDLE state, counter reaching TMO-1 without an FE: go to IDLE, pulse TIMEOUT, push nothing.
- FSM:
  - IDLE: FE with RX_ENABLE=1 and data=0 -> DATA; bit count=0. FE with data=1 is ignored.
  - DATA: on each FE, shift the bit in LSB-first. After the 8th bit -> PARITY.
  - PARITY: on FE, error bit0 = (ones in data + parity bit) is even when PARITY_ODD=1, or odd when PARITY_ODD=0. Go to STOP.
  - STOP: on FE, error bit1 = (data==0). Go to PUSH.
  - PUSH: one cycle; write {err, byte} to the FIFO; go to IDLE.
- RX_ENABLE deasserted mid-frame does not abort the frame. It only gates the start condition.
- Frames with errors are still pushed; the consumer decides what to do with them.
- Latency: entry written the cycle after PUSH; RD_VALID rises on that edge. FE on the stop bit to RD_VALID=1 is 2 CLK cycles.
- FIFO is first-word-fall-through:
  - RD_DATA/RD_ERR show the head combinationally from storage.
  - Pop occurs on a cycle with RD_EN=1 and RD_VALID=1.
  - Simultaneous push and pop: FIFO_COUNT unchanged; legal even when full.
  - Push when full with no pop: entry dropped, FIFO contents unchanged, OVERFLOW=1.
  - OVERFLOW_CLR and a new overflow in the same cycle: OVERFLOW stays 1.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- RESET mid-frame or mid-FIFO: everything returns to its reset value on the next edge; partial frames are discarded.

Optional Feature:
Macro PS2_RX_STATS_EN.
- Defined:
  - FRAMES_OK increments on each PUSH with err=00.
  - FRAMES_ERR increments on each PUSH with err!=00 and on each TIMEOUT.
  - Both counters saturate at 16'hFFFF and clear only on RESET.
  - Counting is independent of FIFO overflow.
- Undefined: FRAMES_OK and FRAMES_ERR are tied to 0 and no counter logic is built.

Test Plan:
- Frame 0xFA, parity bit 1, stop 1, 10 kHz PS/2 clock -> RD_VALID=1 two cycles after the stop FE; RD_DATA=0xFA, RD_ERR=00, FIFO_COUNT=1; RD_EN pulse -> FIFO_COUNT=0, RD_VALID=0.
- Frame 0x08 with parity bit 1 (wrong) -> RD_ERR=01. Frame 0x08, parity 0, stop 0 -> RD_ERR=10. With PS2_RX_STATS_EN: FRAMES_ERR=2.
- Start bit and 4 data bits, then PS2 clock held high for 100000 cycles -> single TIMEOUT pulse, FIFO_COUNT=0. Next frame 0xAA is received correctly.
- 9 frames 0x01..0x09 with no reads (FIFO_DEPTH=8) -> FIFO_COUNT=8, OVERFLOW=1. Reads return 0x01..0x08 in order. OVERFLOW_CLR -> OVERFLOW=0.
- 2-cycle low glitch on PS2_CLK_IN while IDLE, data low, FILTER_LEN=4 -> no frame started; a following valid 0x55 frame is received with RD_ERR=00.
- FIFO full and push coincides with RD_EN=1 -> FIFO_COUNT stays 8, new byte stored, OVERFLOW stays 0.
